race_ctrl: RTL

RACE_CTRL -- requirements
Module: race_ctrl

---
 rtl/race_pkg.sv | 39 +++
 rtl/race_player.sv | 66 ++++++
 rtl/race_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/race_pkg.sv
// Shared encodings and helpers for the two-player drag race controller.
package race_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACE      = 2'd2,
        ST_FINISH    = 2'd3
    } race_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_TIE  = 2'd3
    } winner_e;

    localparam logic [3:0] KEY_NONE   = 4'h0;
    localparam logic [3:0] KEY_P1_GAS = 4'h1;
    localparam logic [3:0] KEY_P2_GAS = 4'h3;
    localparam logic [3:0] KEY_ESC    = 4'hF;

    localparam int XW    = 11;
    localparam int CNT_W = 16;

    // One extra bit keeps the sum exact before the finish-line clamp.
    function automatic logic [XW-1:0] clamp_add(input logic [XW-1:0] x,
                                                 input logic [XW-1:0] d,
                                                 input logic [XW-1:0] lim);
        logic [XW:0] sum;
        sum = {1'b0, x} + {1'b0, d};
        if (sum >= {1'b0, lim}) begin
            return lim;
        end else begin
            return sum[XW-1:0];
        end
    endfunction

endpackage

// File: rtl/race_player.sv
// One car: speed and x position, with gas, frame tick, decay and clear controls.
module race_player
    import race_pkg::*;
#(
    parameter int START_X   = 256,
    parameter int FINISH_X  = 960,
    parameter int MAX_SPEED = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gas,
    input  logic          tick,
    input  logic          decay,
    input  logic          clear,
    output logic [XW-1:0] xpos,
    output logic          at_finish
);

    localparam logic [XW-1:0] START_C  = XW'(START_X);
    localparam logic [XW-1:0] FINISH_C = XW'(FINISH_X);
    localparam logic [XW-1:0] MAX_C    = XW'(MAX_SPEED);

    logic [XW-1:0] xpos_q, xpos_d;
    logic [XW-1:0] speed_q, speed_d;
    logic [XW-1:0] next_x;
    logic [XW-1:0] spd_inc;

    // Position moves with the old speed; gas and decay combine into the new speed.
    always_comb begin
        next_x  = clamp_add(xpos_q, speed_q, FINISH_C);
        spd_inc = speed_q;
        xpos_d  = xpos_q;
        speed_d = speed_q;
        if (gas && (speed_q < MAX_C)) begin
            spd_inc = speed_q + 11'd1;
        end else begin
            spd_inc = speed_q;
        end
        if (clear) begin
            xpos_d  = START_C;
            speed_d = 11'd0;
        end else begin
            xpos_d = tick ? next_x : xpos_q;
            if (decay && (spd_inc != 11'd0)) begin
                speed_d = spd_inc - 11'd1;
            end else begin
                speed_d = spd_inc;
            end
        end
    end

    // Player state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xpos_q  <= START_C;
            speed_q <= 11'd0;
        end else begin
            xpos_q  <= xpos_d;
            speed_q <= speed_d;
        end
    end

    assign xpos      = xpos_q;
    assign at_finish = tick & ~clear & (next_x == FINISH_C);

endmodule

// File: rtl/race_ctrl.sv
// Race flow: idle, 3-2-1 countdown, race with speed decay, finish and winner.
module race_ctrl
    import race_pkg::*;
#(
    parameter int START_X      = 256,
    parameter int FINISH_X     = 960,
    parameter int MAX_SPEED    = 15,
    parameter int COUNT_FRAMES = 60,
    parameter int DECAY_FRAMES = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    keyboard_in,
    input  logic          vsync_in,
    output logic [XW-1:0] xpos_p1,
    output logic [XW-1:0] xpos_p2,
    output logic [1:0]    race_state,
    output logic [1:0]    countdown,
    output logic [1:0]    winner
);

    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT_FRAMES - 1);
    localparam logic [CNT_W-1:0] DECAY_LAST = CNT_W'(DECAY_FRAMES - 1);

    race_state_e      state_q;
    winner_e          winner_q;
    logic [1:0]       countdown_q;
    logic [CNT_W-1:0] cnt_q;
    logic             vsync_q;

    logic tick, gas1, gas2, esc, go_idle, in_race;
    logic p_tick, p_gas1, p_gas2, decay, clear, fin1, fin2;

    // Key decode, frame tick and player control strobes.
    always_comb begin
        tick    = vsync_in & ~vsync_q;
        gas1    = (keyboard_in == KEY_P1_GAS);
        gas2    = (keyboard_in == KEY_P2_GAS);
        esc     = (keyboard_in == KEY_ESC);
        go_idle = esc | ~start;
        in_race = (state_q == ST_RACE);
        p_tick  = tick & in_race;
        p_gas1  = gas1 & in_race;
        p_gas2  = gas2 & in_race;
        if (p_tick && (cnt_q == DECAY_LAST)) begin
            decay = 1'b1;
        end else begin
            decay = 1'b0;
        end
        clear = (state_q == ST_IDLE) | go_idle;
    end

    // vsync history; reset high so a level already high at release is not a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync_in;
        end
    end

    // Race state machine with registered countdown and winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            countdown_q <= 2'd0;
            winner_q    <= WIN_NONE;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_COUNTDOWN;
                        countdown_q <= 2'd3;
                        winner_q    <= WIN_NONE;
                        cnt_q       <= {CNT_W{1'b0}};
                    end
                end
                ST_COUNTDOWN: begin
                    if (go_idle) begin
                        state_q     <= ST_IDLE;
                        countdown_q <= 2'd0;
                        winner_q    <= WIN_NONE;
                        cnt_q       <= {CNT_W{1'b0}};
                    end else if (gas1) begin
                        state_q     <= ST_FINISH;
                        countdown_q <= 2'd0;
                        winner_q    <= WIN_P2;
                    end else if (gas2) begin
                        state_q     <= ST_FINISH;
                        countdown_q <= 2'd0;
                        winner_q    <= WIN_P1;
                    end else if (tick) begin
                        if (cnt_q == COUNT_LAST) begin
                            cnt_q <= {CNT_W{1'b0}};
                            if (countdown_q == 2'd1) begin
                                state_q     <= ST_RACE;
                                countdown_q <= 2'd0;
                            end else begin
                                countdown_q <= countdown_q - 2'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                ST_RACE: begin
                    if (go_idle) begin
                        state_q  <= ST_IDLE;
                        winner_q <= WIN_NONE;
                        cnt_q    <= {CNT_W{1'b0}};
                    end else if (tick) begin
                        cnt_q <= (cnt_q == DECAY_LAST) ? {CNT_W{1'b0}} : cnt_q + 16'd1;
                        if (fin1 || fin2) begin
                            state_q  <= ST_FINISH;
                            winner_q <= winner_e'({fin2, fin1});
                        end
                    end
                end
                ST_FINISH: begin
                    if (go_idle) begin
                        state_q  <= ST_IDLE;
                        winner_q <= WIN_NONE;
                        cnt_q    <= {CNT_W{1'b0}};
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    countdown_q <= 2'd0;
                    winner_q    <= WIN_NONE;
                    cnt_q       <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    race_player #(
        .START_X  (START_X),
        .FINISH_X (FINISH_X),
        .MAX_SPEED(MAX_SPEED)
    ) u_p1 (
        .clk      (clk),
        .rst      (rst),
        .gas      (p_gas1),
        .tick     (p_tick),
        .decay    (decay),
        .clear    (clear),
        .xpos     (xpos_p1),
        .at_finish(fin1)
    );

    race_player #(
        .START_X  (START_X),
        .FINISH_X (FINISH_X),
        .MAX_SPEED(MAX_SPEED)
    ) u_p2 (
        .clk      (clk),
        .rst      (rst),
        .gas      (p_gas2),
        .tick     (p_tick),
        .decay    (decay),
        .clear    (clear),
        .xpos     (xpos_p2),
        .at_finish(fin2)
    );

    assign race_state = state_q;
    assign countdown  = countdown_q;
    assign winner     = winner_q;

endmodule
